sram1p_pipe: RTL
================

# sram1p_pipe

Parametrised single-port SRAM, successor to the basic 1-port macro model, for history buffers and hash tables. Adds per-lane write masking, a selectable read-during-write mode, a configurable read-latency output pipeline with a valid strobe, and an optional post-reset clear sweep. Requests use a ready/valid interface gated by the clear sweep. Responses come out of a fixed-latency pipeline.

## Interface
- WORD_SIZE, 64: data word width in bits.
- ADDR_SIZE, 10: address width; depth = 2^ADDR_SIZE.
- LANE_SIZE, 8: write-mask granularity in bits; WORD_SIZE % LANE_SIZE == 0.
- READ_LATENCY, 1: cycles from accepted request to response; legal 1..3.
- WRITE_MODE, 0: 0 = NO_CHANGE, 1 = WRITE_FIRST, 2 = READ_FIRST.
- CLEAR_ON_RESET, 1: 1 = zero all words after reset before accepting requests.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_SIZE  word address.
- req_wdata  in  WORD_SIZE  write data.
- req_wmask  in  WORD_SIZE/LANE_SIZE  per-lane write enable; bit i covers bits [i*LANE_SIZE +: LANE_SIZE].
- rsp_valid  out  1  rsp_rdata is valid this cycle; single-cycle strobe per response.
- rsp_rdata  out  WORD_SIZE  response data.
- init_done  out  1  clear sweep finished; stays high until the next rst.

## Operation
- FSM states: CLEAR, READY.
- rst forces CLEAR, clear counter = 0, flushes the response pipeline, and drives all outputs low.
- If CLEAR_ON_RESET=0, the state moves from CLEAR to READY on the first cycle after rst deasserts, with no memory writes.
- CLEAR sweep, one word per cycle:
  - Writes zero to address = counter, then increments the counter.
  - After writing address 2^ADDR_SIZE-1, moves to READY and sets init_done.
- In READY, req_ready = 1 every cycle; in CLEAR, req_ready = 0. A request is accepted when req_valid && req_ready.
- Accepted read: returns mem[addr].
- Accepted write:
  - Each lane with a mask bit of 1 takes req_wdata; unmasked lanes keep their old value.
  - An all-zero mask leaves memory unchanged but still counts as a write for responses.
- Write responses by WRITE_MODE:
  - NO_CHANGE: no response.
  - WRITE_FIRST: one response carrying the merged new word.
  - READ_FIRST: one response carrying the pre-write word.
- rsp_rdata holds its last value while rsp_valid = 0.
- Memory contents are not cleared by rst unless CLEAR_ON_RESET=1.

## Timing
- Reset values:
  - Outputs: req_ready = 0, rsp_valid = 0, rsp_rdata = 0, init_done = 0.
  - Internal: all pipeline valid bits = 0.
- Latency: a response for a request accepted at edge N appears at edge N+READY_LATENCY is wrong; precisely, it appears after edge N+READ_LATENCY-1 and is sampled at edge N+READ_LATENCY.
- Back-to-back requests are accepted every cycle, so throughput is 1 per cycle. Responses keep request order.
- Read-after-write to the same address on consecutive cycles returns the newly written data. The array write completes at the write's acceptance edge.
- Clear sweep length with CLEAR_ON_RESET=1: req_ready and init_done rise together, 2^ADDR_SIZE cycles after the first cycle with rst low.
- Reset mid-operation:
  - In-flight responses are dropped: rsp_valid = 0 from the cycle after the rst edge.
  - A partially completed sweep restarts from address 0.
- The response path has no back-pressure; the consumer must always accept.

## Structure
- Shared package sram_pkg holds:
  - the WRITE_MODE constants (WM_NO_CHANGE, WM_WRITE_FIRST, WM_READ_FIRST);
  - the FSM state encoding (ST_CLEAR, ST_READY).
- Sub-module sram_rsp_pipe: a delay line of READ_LATENCY-1 stages of {valid, data} with synchronous reset on the valid bits only. The array read register forms stage 1.
- Masked merge is a generate loop over lanes inside sram1p_pipe.

## Test plan
- Clear sweep, ADDR_SIZE=4, CLEAR_ON_RESET=1:
  - Stimulus: rst for 2 cycles, then release.
  - Required: req_ready = 0 for 16 cycles, then req_ready = init_done = 1.
  - Reading addresses 0..15 returns 0.
- Masked write, WORD_SIZE=32, LANE_SIZE=8:
  - Stimulus: write 0x11223344 mask 0xF, then write 0xAABBCCDD mask 0x5, then read.
  - Required: read returns 0x11BB33DD.
- Read-during-write, same address holding 0x5:
  - Stimulus: write 0x9 mask all-ones.
  - Required: READ_FIRST returns 0x5; WRITE_FIRST returns 0x9; NO_CHANGE gives no rsp_valid.
- Latency, READ_LATENCY=3:
  - Stimulus: 4 consecutive reads of addresses 1..4.
  - Required: rsp_valid high 3 cycles after each acceptance, 4 consecutive strobes, data in order.
- Reset mid-flight:
  - Stimulus: assert rst one cycle after a read with READ_LATENCY=2.
  - Required: no rsp_valid emitted; sweep restarts at address 0.

Source files
------------

// File: rtl/sram1p_pipe_pkg.sv
// Shared constants for the single-port SRAM: write-mode selectors and the
// encoding of the clear/ready controller.
package sram_pkg;

  // Selects what an accepted write returns on the response path.
  localparam int WM_NO_CHANGE   = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_READ_FIRST  = 2;

  // CLEAR: post-reset zeroing sweep (or a single pass-through cycle).
  // READY: requests accepted every cycle.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/sram1p_pipe_if.sv
// Request/response bundle for sram1p_pipe.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_write/req_addr/req_wdata/req_wmask are
// sampled on that edge only. req_ready does not depend on req_valid.
// Responses have no back-pressure: rsp_valid is a one-cycle strobe and the
// consumer must take rsp_rdata in that cycle. rsp_rdata holds otherwise.
interface sram1p_pipe_if #(
  parameter int WORD_SIZE = 64,
  parameter int ADDR_SIZE = 10,
  parameter int LANE_SIZE = 8
);
  logic                           req_valid;
  logic                           req_ready;
  logic                           req_write;
  logic [ADDR_SIZE-1:0]           req_addr;
  logic [WORD_SIZE-1:0]           req_wdata;
  logic [WORD_SIZE/LANE_SIZE-1:0] req_wmask;
  logic                           rsp_valid;
  logic [WORD_SIZE-1:0]           rsp_rdata;
  logic                           init_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, init_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, init_done
  );
endinterface

// File: rtl/sram1p_pipe_rsp_pipe.sv
// Response delay line: STAGES registers of {valid, data} behind the array
// read register. Data only advances alongside a valid bit, so the output
// data holds its last response between strobes.
module sram_rsp_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_stages
    logic [STAGES-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    // Shift valid bits every cycle; move data only with a valid bit.
    always_comb begin
      vld_d[0]  = in_valid;
      data_d[0] = in_valid ? in_data : data_q[0];
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i]  = vld_q[i-1];
        data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
      end
    end

    // Valid bits reset; the last data stage also clears so the visible
    // response data reads zero out of reset.
    always_ff @(posedge clk) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_q[i] <= rst ? 1'b0 : vld_d[i];
        if (rst && (i == STAGES - 1)) data_q[i] <= '0;
        else                          data_q[i] <= data_d[i];
      end
    end

    assign out_valid = vld_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
  end

endmodule

// File: rtl/sram1p_pipe.sv
// Single-port SRAM with per-lane write mask, selectable read-during-write
// response, fixed read latency (1..3) and an optional post-reset zeroing
// sweep that holds off requests until every word is cleared.
module sram1p_pipe
  import sram_pkg::*;
#(
  parameter int WORD_SIZE      = 64,
  parameter int ADDR_SIZE      = 10,
  parameter int LANE_SIZE      = 8,
  parameter int READ_LATENCY   = 1,
  parameter int WRITE_MODE     = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic           clk,
  input  logic           rst,
  sram1p_pipe_if.slave   bus,
  output state_t         dbg_state
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int LANES = WORD_SIZE / LANE_SIZE;
  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = '1;

  state_t               state_q, state_d;
  logic [ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic                 clr_we;
  logic                 ready;
  logic                 accept;

  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_waddr;
  logic [WORD_SIZE-1:0] mem_wdata;

  logic [WORD_SIZE-1:0] rd_word;
  logic [WORD_SIZE-1:0] merged;
  logic                 rsp_gen;
  logic [WORD_SIZE-1:0] rsp_word;

  logic                 s1_valid_q, s1_valid_d;
  logic [WORD_SIZE-1:0] s1_data_q, s1_data_d;

  // Requests are only taken in READY and never on a reset edge.
  assign ready  = (state_q == ST_READY) && !rst;
  assign accept = bus.req_valid && ready;

  assign rd_word = mem_q[bus.req_addr];

  // Per-lane merge: enabled lanes take the new data, others keep the old word.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign merged[i*LANE_SIZE +: LANE_SIZE] =
      bus.req_wmask[i] ? bus.req_wdata[i*LANE_SIZE +: LANE_SIZE]
                       : rd_word[i*LANE_SIZE +: LANE_SIZE];
  end

  // Controller next state: sweep one word per cycle, then sit in READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          clr_we = !rst;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) state_d = ST_READY;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_READY: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Controller registers; reset restarts the sweep from address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Single write port shared by the sweep and accepted writes (never both).
  always_comb begin
    mem_we    = clr_we || (accept && bus.req_write);
    mem_waddr = clr_we ? cnt_q : bus.req_addr;
    mem_wdata = clr_we ? '0 : merged;
  end

  // Array write; contents survive reset unless the sweep clears them.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Decide whether this acceptance produces a response and what it carries.
  always_comb begin
    rsp_gen    = accept && (!bus.req_write || (WRITE_MODE != WM_NO_CHANGE));
    rsp_word   = (bus.req_write && (WRITE_MODE == WM_WRITE_FIRST)) ? merged : rd_word;
    s1_valid_d = rsp_gen;
    s1_data_d  = rsp_gen ? rsp_word : s1_data_q;
  end

  // Array read register: first stage of the response latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  sram_rsp_pipe #(
    .WIDTH  (WORD_SIZE),
    .STAGES (READ_LATENCY - 1)
  ) u_rsp_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s1_valid_q),
    .in_data   (s1_data_q),
    .out_valid (bus.rsp_valid),
    .out_data  (bus.rsp_rdata)
  );

  assign bus.req_ready = ready;
  assign bus.init_done = ready;
  assign dbg_state     = state_q;

endmodule
